// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the architectural PC, issues in-order word
// requests to instruction memory, and buffers returned instructions (tagged
// with their PC) in a small FIFO whose head feeds the control/decode unit.
//
// Handshake semantics (both request and retire sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   Once mem_req_valid_out is raised in RUN it stays high with a stable
//   mem_req_addr_out until accepted, even across a redirect. Responses are
//   always accepted (no backpressure) and return in request order.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid_out,
    input  logic        mem_req_ready_in,
    output logic [31:0] mem_req_addr_out,
    input  logic        mem_rsp_valid_in,
    input  logic [31:0] mem_rsp_data_in,
    input  logic        mem_rsp_err_in,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc_out,
    input  logic        instr_ready_in,
    input  logic [31:0] pc_next_in,
    output logic        fault_out,
    output logic [31:0] fault_pc_out,
    output logic        dbg_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 2;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d, outstanding_post;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          stale_q, stale_d;
    logic [31:0]   stale_addr_q, stale_addr_d;
    logic          fault_q, fault_d;
    logic [31:0]   fault_pc_q, fault_pc_d;

    logic [31:0]   fifo_data [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];

    logic [SW-1:0] credit_sum;
    logic          handshake;
    logic          retire;
    logic          redirect;
    logic          push;
    logic          pop;

    // Request, FIFO head and retire decode. A stale request (pending when a
    // redirect hit) is held regardless of credit so its address stays stable.
    always_comb begin
        credit_sum        = SW'(outstanding_q) + SW'(count_q) + SW'(discard_q);
        mem_req_valid_out = !rst && (state_q == RUN) &&
                            (stale_q || (credit_sum < SW'(FIFO_DEPTH)));
        mem_req_addr_out  = stale_q ? stale_addr_q : fetch_pc_q;
        handshake         = mem_req_valid_out && mem_req_ready_in;
        instr_valid_out   = (state_q == RUN) && (count_q != '0);
        instr_out         = fifo_data[rd_ptr_q];
        instr_pc_out      = fifo_pc[rd_ptr_q];
        retire            = instr_valid_out && instr_ready_in;
        redirect          = retire && (pc_next_in != instr_pc_out + 32'd4);
        fault_out         = fault_q;
        fault_pc_out      = fault_pc_q;
        dbg_state         = (state_q == HALT);
    end

    // Next-state logic: credits, response disposition, retire and redirect.
    always_comb begin
        state_d          = state_q;
        fetch_pc_d       = fetch_pc_q;
        rsp_pc_d         = rsp_pc_q;
        discard_d        = discard_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        stale_d          = stale_q;
        stale_addr_d     = stale_addr_q;
        fault_d          = fault_q;
        fault_pc_d       = fault_pc_q;
        push             = 1'b0;
        pop              = retire;
        outstanding_post = outstanding_q + CW'(handshake) - CW'(mem_rsp_valid_in);
        outstanding_d    = outstanding_post;

        // An accepted stale request fetches a dead address: its response
        // must be dropped, and fetch_pc already points at the new target.
        if (handshake) begin
            if (stale_q) begin
                stale_d   = 1'b0;
                discard_d = discard_d + CW'(1);
            end else begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
        end

        // A response arriving with a redirect is simply dropped; it was
        // already removed from outstanding_post so it is not discarded twice.
        if (mem_rsp_valid_in && !redirect) begin
            if (discard_q != '0) begin
                discard_d = discard_d - CW'(1);
            end else if (state_q == RUN) begin
                if (mem_rsp_err_in) begin
                    state_d    = HALT;
                    fault_d    = 1'b1;
                    fault_pc_d = rsp_pc_q;
                end else begin
                    push     = 1'b1;
                    rsp_pc_d = rsp_pc_q + 32'd4;
                end
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (redirect) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            discard_d  = outstanding_post;
            fetch_pc_d = pc_next_in;
            rsp_pc_d   = pc_next_in;
            if (mem_req_valid_out && !mem_req_ready_in) begin
                stale_d      = 1'b1;
                stale_addr_d = mem_req_addr_out;
            end
            if (pc_next_in[1:0] != 2'b00) begin
                state_d    = HALT;
                fault_d    = 1'b1;
                fault_pc_d = pc_next_in;
            end
        end

        // HALT keeps the buffer empty and never re-issues a held request.
        if (state_d == HALT) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            stale_d  = 1'b0;
        end
    end

    // Control and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            stale_q       <= 1'b0;
            stale_addr_q  <= '0;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            stale_q       <= stale_d;
            stale_addr_q  <= stale_addr_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    // Instruction buffer storage; cleared on reset so the head reads 0/RESET_PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= RESET_PC;
            end
        end else if (push) begin
            fifo_data[wr_ptr_q] <= mem_rsp_data_in;
            fifo_pc[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model with configurable latency and
// ready, a retire driver that steers pc_next, and per-scenario checks.
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        mem_req_valid_out, mem_req_ready_in;
    logic [31:0] mem_req_addr_out;
    logic        mem_rsp_valid_in, mem_rsp_err_in;
    logic [31:0] mem_rsp_data_in;
    logic        instr_valid_out, instr_ready_in;
    logic [31:0] instr_out, instr_pc_out, pc_next_in;
    logic        fault_out, dbg_state;
    logic [31:0] fault_pc_out;

    instr_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid_out(mem_req_valid_out), .mem_req_ready_in(mem_req_ready_in),
        .mem_req_addr_out(mem_req_addr_out),
        .mem_rsp_valid_in(mem_rsp_valid_in), .mem_rsp_data_in(mem_rsp_data_in),
        .mem_rsp_err_in(mem_rsp_err_in),
        .instr_valid_out(instr_valid_out), .instr_out(instr_out),
        .instr_pc_out(instr_pc_out), .instr_ready_in(instr_ready_in),
        .pc_next_in(pc_next_in), .fault_out(fault_out), .fault_pc_out(fault_pc_out),
        .dbg_state(dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- memory model ----------------
    int          mem_lat_min = 1, mem_lat_max = 1, mem_rdy_pct = 100;
    bit          err_en = 1'b0;
    logic [31:0] err_addr = '0;
    int          n_accepted = 0;
    int          cyc = 0;
    int          last_due = 0;
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    initial begin
        int due;
        mem_req_ready_in = 1'b0;
        mem_rsp_valid_in = 1'b0;
        mem_rsp_data_in  = '0;
        mem_rsp_err_in   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst && mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
                mem_rsp_valid_in = 1'b1;
                mem_rsp_data_in  = mem_word(mem_addr_q[0]);
                mem_rsp_err_in   = err_en && (mem_addr_q[0] == err_addr);
                void'(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end else begin
                mem_rsp_valid_in = 1'b0;
                mem_rsp_data_in  = $urandom;
                mem_rsp_err_in   = 1'($urandom_range(0, 1));
            end
            mem_req_ready_in = ($urandom_range(1, 100) <= mem_rdy_pct);
            @(negedge clk);
            if (rst) begin
                mem_addr_q.delete();
                mem_due_q.delete();
                last_due   = 0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && !fault_out) begin
                    n_vec++;
                    if (mem_req_valid_out !== 1'b1 || mem_req_addr_out !== prev_addr) begin
                        n_err++;
                        $display("FAIL req_stable got=%b/%h exp=1/%h", mem_req_valid_out,
                                 mem_req_addr_out, prev_addr);
                    end
                end
                prev_stall = mem_req_valid_out && !mem_req_ready_in;
                prev_addr  = mem_req_addr_out;
                if (mem_req_valid_out && mem_req_ready_in) begin
                    due = cyc + $urandom_range(mem_lat_min, mem_lat_max);
                    if (due < last_due) due = last_due;
                    last_due = due;
                    mem_addr_q.push_back(mem_req_addr_out);
                    mem_due_q.push_back(due);
                    n_accepted++;
                end
            end
        end
    end

    // ---------------- retire driver / architectural model ----------------
    int          rdy_pct = 100, redir_pct = 0;
    bit          redir_en = 1'b0;
    logic [31:0] redir_from = '0, redir_to = '0;
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] ret_pc_q[$], ret_data_q[$], ret_next_q[$];
    logic [31:0] exp_q[$];

    initial begin
        instr_ready_in = 1'b0;
        pc_next_in     = '0;
        forever begin
            @(posedge clk);
            #1;
            instr_ready_in = ($urandom_range(1, 100) <= rdy_pct);
            if (redir_en && model_pc == redir_from)
                pc_next_in = redir_to;
            else if ($urandom_range(1, 100) <= redir_pct)
                pc_next_in = ($urandom_range(0, 3) == 0) ?
                             (32'hFFFF_FFE0 + ($urandom_range(0, 7) << 2)) :
                             ($urandom_range(0, 255) << 2);
            else
                pc_next_in = model_pc + 32'd4;
            @(negedge clk);
            if (!rst && instr_valid_out && instr_ready_in) begin
                ret_pc_q.push_back(instr_pc_out);
                ret_data_q.push_back(instr_out);
                ret_next_q.push_back(pc_next_in);
                if (redir_en && model_pc == redir_from) redir_en = 1'b0;
                model_pc = pc_next_in;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_cfg(input int lat_min, input int lat_max, input int mrdy,
                           input int rrdy, input int rpct);
        mem_lat_min = lat_min;
        mem_lat_max = lat_max;
        mem_rdy_pct = mrdy;
        rdy_pct     = rrdy;
        redir_pct   = rpct;
        redir_en    = 1'b0;
        err_en      = 1'b0;
    endtask

    // Returns at the start of cycle 0, the first cycle with rst low.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        model_pc = RESET_PC;
        ret_pc_q.delete();
        ret_data_q.delete();
        ret_next_q.delete();
        n_accepted = 0;
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_cfg(1, 1, 100, 100, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (mem_req_valid_out !== 1'b0 || mem_req_addr_out !== RESET_PC) begin
            n_err++;
            $display("FAIL reset_req got=%b/%h exp=0/%h", mem_req_valid_out, mem_req_addr_out, RESET_PC);
        end
        n_vec++;
        if (instr_valid_out !== 1'b0 || instr_out !== 32'h0 || instr_pc_out !== RESET_PC) begin
            n_err++;
            $display("FAIL reset_head got=%b/%h/%h exp=0/0/%h", instr_valid_out, instr_out,
                     instr_pc_out, RESET_PC);
        end
        n_vec++;
        if (fault_out !== 1'b0 || fault_pc_out !== 32'h0 || dbg_state !== 1'b0) begin
            n_err++;
            $display("FAIL reset_fault got=%b/%h/%b exp=0/0/0", fault_out, fault_pc_out, dbg_state);
        end
        @(posedge clk);
        #3;
        model_pc = RESET_PC;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (mem_req_valid_out !== 1'b1 || mem_req_addr_out !== RESET_PC) begin
            n_err++;
            $display("FAIL first_req got=%b/%h exp=1/%h", mem_req_valid_out, mem_req_addr_out, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] pc;
        set_cfg(1, 1, 100, 100, 0);
        do_reset();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                pc = 32'(4 * (c - 2));
                n_vec++;
                if (instr_valid_out !== 1'b1 || instr_pc_out !== pc || instr_out !== mem_word(pc)) begin
                    n_err++;
                    $display("FAIL seq_c%0d got=%b/%h/%h exp=1/%h/%h", c, instr_valid_out,
                             instr_pc_out, instr_out, pc, mem_word(pc));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        set_cfg(1, 1, 100, 0, 0);
        do_reset();
        repeat (10) @(negedge clk);
        #1;
        n_vec++;
        if (n_accepted != DEPTH) begin
            n_err++;
            $display("FAIL bp_accepted got=%0d exp=%0d", n_accepted, DEPTH);
        end
        n_vec++;
        if (instr_valid_out !== 1'b1 || instr_pc_out !== 32'h0 || mem_req_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold got=%b/%h/%b exp=1/0/0", instr_valid_out, instr_pc_out,
                     mem_req_valid_out);
        end
        @(posedge clk);
        #3;
        rdy_pct = 100;
        repeat (12) @(negedge clk);
        #1;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= ret_pc_q.size()) begin
                n_err++;
                $display("FAIL bp_ret%0d got=none exp=%h", i, exp_q[i]);
            end else if (ret_pc_q[i] !== exp_q[i] || ret_data_q[i] !== mem_word(exp_q[i])) begin
                n_err++;
                $display("FAIL bp_ret%0d got=%h/%h exp=%h/%h", i, ret_pc_q[i], ret_data_q[i],
                         exp_q[i], mem_word(exp_q[i]));
            end
        end
    endtask

    task automatic test_redirect();
        set_cfg(3, 3, 100, 100, 0);
        redir_from = 32'h8;
        redir_to   = 32'h100;
        redir_en   = 1'b1;
        do_reset();
        repeat (40) @(negedge clk);
        #1;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104, 32'h108};
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= ret_pc_q.size()) begin
                n_err++;
                $display("FAIL redir_ret%0d got=none exp=%h", i, exp_q[i]);
            end else if (ret_pc_q[i] !== exp_q[i] || ret_data_q[i] !== mem_word(exp_q[i])) begin
                n_err++;
                $display("FAIL redir_ret%0d got=%h/%h exp=%h/%h", i, ret_pc_q[i], ret_data_q[i],
                         exp_q[i], mem_word(exp_q[i]));
            end
        end
    endtask

    task automatic test_misaligned();
        int ret_cyc, fault_cyc, req_after;
        set_cfg(1, 2, 100, 100, 0);
        redir_from = 32'h4;
        redir_to   = 32'h102;
        redir_en   = 1'b1;
        ret_cyc    = -1;
        fault_cyc  = -1;
        req_after  = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (instr_valid_out && instr_ready_in && instr_pc_out == 32'h4) ret_cyc = c;
            if (fault_out && fault_cyc < 0) fault_cyc = c;
            if (fault_out && mem_req_valid_out) req_after++;
        end
        #1;
        n_vec++;
        if (fault_out !== 1'b1 || fault_pc_out !== 32'h102 || dbg_state !== 1'b1) begin
            n_err++;
            $display("FAIL mis_fault got=%b/%h/%b exp=1/00000102/1", fault_out, fault_pc_out, dbg_state);
        end
        n_vec++;
        if (ret_cyc < 0 || fault_cyc != ret_cyc + 1) begin
            n_err++;
            $display("FAIL mis_fault_timing got=%0d exp=%0d", fault_cyc, ret_cyc + 1);
        end
        n_vec++;
        if (req_after != 0 || instr_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL mis_quiet got=%0d/%b exp=0/0", req_after, instr_valid_out);
        end
        n_vec++;
        if (ret_pc_q.size() != 2) begin
            n_err++;
            $display("FAIL mis_ret_count got=%0d exp=2", ret_pc_q.size());
        end
    endtask

    task automatic test_bus_error();
        set_cfg(1, 3, 100, 100, 0);
        err_en   = 1'b1;
        err_addr = 32'h10;
        do_reset();
        repeat (30) @(negedge clk);
        #1;
        n_vec++;
        if (fault_out !== 1'b1 || fault_pc_out !== 32'h10 || dbg_state !== 1'b1) begin
            n_err++;
            $display("FAIL berr_fault got=%b/%h/%b exp=1/00000010/1", fault_out, fault_pc_out, dbg_state);
        end
        n_vec++;
        if (instr_valid_out !== 1'b0 || mem_req_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL berr_quiet got=%b/%b exp=0/0", instr_valid_out, mem_req_valid_out);
        end
        n_vec++;
        if (ret_pc_q.size() != 4) begin
            n_err++;
            $display("FAIL berr_ret_count got=%0d exp=4", ret_pc_q.size());
        end
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        for (int i = 0; i < exp_q.size() && i < ret_pc_q.size(); i++) begin
            n_vec++;
            if (ret_pc_q[i] !== exp_q[i] || ret_data_q[i] !== mem_word(exp_q[i])) begin
                n_err++;
                $display("FAIL berr_ret%0d got=%h/%h exp=%h/%h", i, ret_pc_q[i], ret_data_q[i],
                         exp_q[i], mem_word(exp_q[i]));
            end
        end
        err_en = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        set_cfg(1, 3, 70, 75, 0);
        redir_from = 32'h4;
        redir_to   = 32'hFFFF_FFF8;
        redir_en   = 1'b1;
        do_reset();
        repeat (80) @(negedge clk);
        #1;
        exp_q = '{32'h0, 32'h4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= ret_pc_q.size()) begin
                n_err++;
                $display("FAIL wrap_ret%0d got=none exp=%h", i, exp_q[i]);
            end else if (ret_pc_q[i] !== exp_q[i] || ret_data_q[i] !== mem_word(exp_q[i])) begin
                n_err++;
                $display("FAIL wrap_ret%0d got=%h/%h exp=%h/%h", i, ret_pc_q[i], ret_data_q[i],
                         exp_q[i], mem_word(exp_q[i]));
            end
        end
        // Synchronous reset in the middle of traffic.
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (instr_valid_out !== 1'b0 || mem_req_valid_out !== 1'b0 || fault_out !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_hold got=%b/%b/%b exp=0/0/0", instr_valid_out, mem_req_valid_out, fault_out);
        end
        @(posedge clk);
        #3;
        model_pc = RESET_PC;
        ret_pc_q.delete();
        ret_data_q.delete();
        ret_next_q.delete();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (mem_req_valid_out !== 1'b1 || mem_req_addr_out !== RESET_PC || instr_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_first got=%b/%h/%b exp=1/%h/0", mem_req_valid_out, mem_req_addr_out,
                     instr_valid_out, RESET_PC);
        end
        repeat (30) @(negedge clk);
        #1;
        exp_q = '{32'h0, 32'h4, 32'h8};
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= ret_pc_q.size() || ret_pc_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL midrst_ret%0d got=%h exp=%h", i,
                         (i < ret_pc_q.size()) ? ret_pc_q[i] : 32'hx, exp_q[i]);
            end
        end
    endtask

    // Random traffic: every retired instruction must be the architectural
    // successor of the previous retire (pc+4 or the steered target).
    task automatic test_random();
        logic [31:0] exp_pc;
        for (int r = 0; r < 4; r++) begin
            set_cfg(1, $urandom_range(1, 4), $urandom_range(40, 100), $urandom_range(40, 100), 15);
            do_reset();
            repeat (400) @(negedge clk);
            #1;
            exp_pc = RESET_PC;
            for (int i = 0; i < ret_pc_q.size(); i++) begin
                n_vec++;
                if (ret_pc_q[i] !== exp_pc || ret_data_q[i] !== mem_word(exp_pc)) begin
                    n_err++;
                    $display("FAIL rand%0d_ret%0d got=%h/%h exp=%h/%h", r, i, ret_pc_q[i],
                             ret_data_q[i], exp_pc, mem_word(exp_pc));
                end
                exp_pc = ret_next_q[i];
            end
            n_vec++;
            if (ret_pc_q.size() < 40) begin
                n_err++;
                $display("FAIL rand%0d_progress got=%0d exp>=40", r, ret_pc_q.size());
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_bus_error();
        test_wrap_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
